// File: rtl/sys_array_argmax.sv
// sys_array_argmax: captures ARRAY_W signed class scores from the systolic
// array, optionally adds a per-class bias, then scans one class per clock to
// find the maximum score and its index. The result is offered on a
// valid/ready handshake; ties resolve to the lowest index.
// Optional feature macro: ARGMAX_BIAS_EN (adds bias[i] to scores[i] on capture).
module sys_array_argmax #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic signed [0:ARRAY_W-1][2*DATA_WIDTH-1:0] scores,
    input  logic signed [0:ARRAY_W-1][2*DATA_WIDTH-1:0] bias,
    output logic                                        busy,
    output logic                                        result_valid,
    input  logic                                        result_ready,
    output logic        [IDX_WIDTH-1:0]                 class_idx,
    output logic signed [2*DATA_WIDTH:0]                class_score
);

    localparam int SW = 2 * DATA_WIDTH;
    localparam int BW = SW + 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ARRAY_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   idx;
    logic [IDX_WIDTH-1:0]   best_idx;
    logic signed [BW-1:0]   best_score;
    logic signed [BW-1:0]   bank        [0:ARRAY_W-1];
    logic signed [BW-1:0]   capture_val [0:ARRAY_W-1];
    logic                   capture;

`ifdef ARGMAX_BIAS_EN
    // Widen each score and bias by one guard bit so the sum can never wrap.
    always_comb begin
        for (int i = 0; i < ARRAY_W; i++) begin
            capture_val[i] = {scores[i][SW-1], scores[i]} + {bias[i][SW-1], bias[i]};
        end
    end
`else
    // Widen each score by one guard bit; bias is not part of this build.
    always_comb begin
        for (int i = 0; i < ARRAY_W; i++) begin
            capture_val[i] = {scores[i][SW-1], scores[i]};
        end
    end

    logic unused_bias;
    assign unused_bias = ^bias;
`endif

    // A new frame is taken from IDLE, or from DONE on the handshake edge.
    assign capture = start && ((state == IDLE) || ((state == DONE) && result_ready));

    // Score bank: loaded only on an accepting edge, no reset needed.
    always_ff @(posedge clk) begin
        if (capture && !reset) begin
            for (int i = 0; i < ARRAY_W; i++) begin
                bank[i] <= capture_val[i];
            end
        end
    end

    // Control FSM with registered busy/valid and running best score/index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            idx          <= '0;
            best_idx     <= '0;
            best_score   <= '0;
        end else if (capture) begin
            best_score <= capture_val[0];
            best_idx   <= '0;
            idx        <= IDX_WIDTH'(1);
            busy       <= 1'b1;
            if (ARRAY_W == 1) begin
                state        <= DONE;
                result_valid <= 1'b1;
            end else begin
                state        <= SCAN;
                result_valid <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                end
                SCAN: begin
                    if (bank[idx] > best_score) begin
                        best_score <= bank[idx];
                        best_idx   <= idx;
                    end
                    if (idx == LAST_IDX) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                    end else begin
                        idx <= idx + IDX_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign class_idx   = best_idx;
    assign class_score = best_score;

endmodule

// File: tb/tb_sys_array_argmax.sv
// Testbench for sys_array_argmax: directed scenarios followed by random frames,
// all checked against a behavioural argmax model computed in the bench.
module tb_sys_array_argmax;

    localparam int DW  = 8;
    localparam int AW  = 10;
    localparam int IW  = 4;
    localparam int SW  = 2 * DW;
    localparam int SCW = SW + 1;
`ifdef ARGMAX_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif

    typedef int vec_t [AW];

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           start;
    logic signed [0:AW-1][SW-1:0]   scores;
    logic signed [0:AW-1][SW-1:0]   bias;
    logic                           busy;
    logic                           result_valid;
    logic                           result_ready;
    logic        [IW-1:0]           class_idx;
    logic signed [SCW-1:0]          class_score;

    int   compared   = 0;
    int   mismatched = 0;
    vec_t curS, curB, altS, altB;
    int   expIdx, expScore, altIdx, altScore;
    int   cycles, busyLow, unstable;

    sys_array_argmax #(
        .DATA_WIDTH(DW),
        .ARRAY_W   (AW),
        .IDX_WIDTH (IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .scores      (scores),
        .bias        (bias),
        .busy        (busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Reference: effective score per class, global maximum, first index hitting it.
    function automatic void refArgmax(input vec_t s, input vec_t b,
                                      output int idxOut, output int scoreOut);
        int v [AW];
        int mx;
        for (int i = 0; i < AW; i++) v[i] = s[i] + (BIAS_ON ? b[i] : 0);
        mx = v[0];
        for (int i = 1; i < AW; i++) if (v[i] > mx) mx = v[i];
        idxOut = -1;
        for (int i = AW - 1; i >= 0; i--) if (v[i] == mx) idxOut = i;
        scoreOut = mx;
    endfunction

    function automatic void randVec(output vec_t v, input int mode);
        logic signed [SW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            if (mode == 0) begin
                r    = SW'($urandom);
                v[i] = int'(r);
            end else begin
                v[i] = int'($urandom_range(0, 8)) - 4;
            end
        end
    endfunction

    task automatic driveBus(input vec_t s, input vec_t b);
        for (int i = 0; i < AW; i++) begin
            scores[i] = SW'(s[i]);
            bias[i]   = SW'(b[i]);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse with the given frame, then garbage on the bus.
    task automatic applyStimulus(input vec_t s, input vec_t b);
        vec_t gs, gb;
        driveBus(s, b);
        start = 1'b1;
        stepClk();
        start = 1'b0;
        randVec(gs, 0);
        randVec(gb, 0);
        driveBus(gs, gb);
    endtask

    task automatic waitValid(output int cyc, output int lowCnt);
        cyc    = 0;
        lowCnt = 0;
        while (result_valid !== 1'b1 && cyc < 40) begin
            stepClk();
            cyc++;
            if (busy !== 1'b1) lowCnt++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        stepClk();
        result_ready = 1'b0;
    endtask

    task automatic runFrame(input string tag, input vec_t s, input vec_t b);
        int ei, es, cyc, low;
        refArgmax(s, b, ei, es);
        applyStimulus(s, b);
        waitValid(cyc, low);
        checkOutput({tag, " latency"}, cyc, AW - 1);
        checkOutput({tag, " idx"}, class_idx, ei);
        checkOutput({tag, " score"}, class_score, es);
        checkOutput({tag, " busy"}, busy, 1);
        handshake();
        checkOutput({tag, " validAfter"}, result_valid, 0);
        checkOutput({tag, " busyAfter"}, busy, 0);
    endtask

    // Directed scenarios followed by random frames.
    initial begin
        $display("[TB] sys_array_argmax bench, bias build = %0d", BIAS_ON);
        reset        = 1'b1;
        start        = 1'b0;
        result_ready = 1'b0;
        scores       = '0;
        bias         = '0;
        repeat (2) stepClk();
        checkOutput("reset busy", busy, 0);
        checkOutput("reset valid", result_valid, 0);
        checkOutput("reset idx", class_idx, 0);
        checkOutput("reset score", class_score, 0);
        reset = 1'b0;
        stepClk();

        curS = '{3, -7, 12, 0, 5, 12, -1, 4, 2, 11};
        curB = '{default: 0};
        runFrame("tiePlan", curS, curB);

        curS = '{default: -32768};
        curB = '{default: 1};
        runFrame("allMin", curS, curB);

        curS    = '{default: 0};
        curB    = '{default: 0};
        curS[4] = 32767;
        curB[4] = 32767;
        runFrame("noWrap", curS, curB);

        // Ready held low; extra starts mid-scan and in DONE must be ignored.
        randVec(curS, 1);
        randVec(curB, 1);
        randVec(altS, 0);
        randVec(altB, 0);
        refArgmax(curS, curB, expIdx, expScore);
        applyStimulus(curS, curB);
        repeat (3) stepClk();
        driveBus(altS, altB);
        start = 1'b1;
        stepClk();
        start = 1'b0;
        waitValid(cycles, busyLow);
        checkOutput("hold latency", cycles, AW - 5);
        driveBus(altS, altB);
        start = 1'b1;
        stepClk();
        start    = 1'b0;
        unstable = 0;
        for (int k = 0; k < 20; k++) begin
            if (result_valid !== 1'b1 || class_idx !== IW'(expIdx) ||
                class_score !== SCW'(expScore)) unstable++;
            stepClk();
        end
        checkOutput("hold stable", unstable, 0);
        checkOutput("hold idx", class_idx, expIdx);
        checkOutput("hold score", class_score, expScore);
        handshake();
        checkOutput("hold validAfter", result_valid, 0);
        checkOutput("hold busyAfter", busy, 0);

        // Back-to-back frames: new start accepted on the handshake edge.
        randVec(curS, 0);
        randVec(curB, 0);
        randVec(altS, 1);
        randVec(altB, 1);
        refArgmax(curS, curB, expIdx, expScore);
        refArgmax(altS, altB, altIdx, altScore);
        applyStimulus(curS, curB);
        waitValid(cycles, busyLow);
        checkOutput("b2b first idx", class_idx, expIdx);
        checkOutput("b2b first score", class_score, expScore);
        driveBus(altS, altB);
        start        = 1'b1;
        result_ready = 1'b1;
        stepClk();
        start        = 1'b0;
        result_ready = 1'b0;
        checkOutput("b2b busyHeld", busy, 1);
        checkOutput("b2b validDrop", result_valid, 0);
        waitValid(cycles, busyLow);
        checkOutput("b2b latency", cycles, AW - 1);
        checkOutput("b2b busyLow", busyLow, 0);
        checkOutput("b2b second idx", class_idx, altIdx);
        checkOutput("b2b second score", class_score, altScore);
        handshake();
        checkOutput("b2b validAfter", result_valid, 0);

        // Reset in the middle of a scan, with a start that must be ignored.
        randVec(curS, 0);
        randVec(curB, 0);
        randVec(altS, 0);
        randVec(altB, 0);
        applyStimulus(curS, curB);
        repeat (3) stepClk();
        driveBus(altS, altB);
        reset = 1'b1;
        start = 1'b1;
        stepClk();
        reset = 1'b0;
        start = 1'b0;
        checkOutput("midReset valid", result_valid, 0);
        checkOutput("midReset busy", busy, 0);
        stepClk();
        checkOutput("midReset idle", busy, 0);
        runFrame("postReset", altS, altB);

        for (int f = 0; f < 16; f++) begin
            randVec(curS, f % 2);
            randVec(curB, f % 2);
            runFrame($sformatf("rand%0d", f), curS, curB);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
